// File: rtl/lane_reorder_pipe_if.sv
// Stream handshake bundle for lane_reorder_pipe: input beat side and output beat side.
// Handshake: a beat moves on a rising edge where valid & ready are both 1; valid never waits on ready.
interface lane_reorder_pipe_if #(
   parameter int LANE_W = 8,
   parameter int LANES  = 4
);
   localparam int DATA_W = LANE_W * LANES;
   localparam int ROT_W  = $clog2(LANES);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [1:0]        in_mode;
   logic [ROT_W-1:0]  in_rot;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;

   modport master (
      output in_valid, in_data, in_mode, in_rot, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_mode, in_rot, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/lane_reorder_pipe.sv
// Pipelined N-lane permuter (pass/reverse/pair-swap/rotate) with a 2-entry output FIFO.
// Optional beat counter enabled by defining LANE_REORDER_PIPE_CNT_EN.
module lane_reorder_pipe #(
   parameter int LANE_W = 8,
   parameter int LANES  = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   lane_reorder_pipe_if.slave   bus
`ifdef LANE_REORDER_PIPE_CNT_EN
   ,
   input  logic                 cnt_clr,
   output logic [31:0]          beat_cnt
`endif
);
   localparam int DATA_W = LANE_W * LANES;

   logic [DATA_W-1:0] perm;
   int                rot_m;

   // Output lane j is written from input lane k; the beat is stored already permuted.
   always_comb begin
      perm  = bus.in_data;
      rot_m = int'(bus.in_rot) % LANES;
      case (bus.in_mode)
         2'd1: begin
            for (int k = 0; k < LANES; k++)
               perm[(LANES-1-k)*LANE_W +: LANE_W] = bus.in_data[k*LANE_W +: LANE_W];
         end
         2'd2: begin
            for (int m = 0; m + 1 < LANES; m += 2) begin
               perm[m*LANE_W +: LANE_W]     = bus.in_data[(m+1)*LANE_W +: LANE_W];
               perm[(m+1)*LANE_W +: LANE_W] = bus.in_data[m*LANE_W +: LANE_W];
            end
         end
         2'd3: begin
            for (int k = 0; k < LANES; k++)
               perm[((k + rot_m) % LANES)*LANE_W +: LANE_W] = bus.in_data[k*LANE_W +: LANE_W];
         end
         default: ;
      endcase
   end

   logic [DATA_W-1:0] mem [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        count;
   logic [1:0]        count_next;
   logic              in_ready_q;
   logic              push;
   logic              pop;

   assign push = bus.in_valid & in_ready_q;
   assign pop  = (count != 2'd0) & bus.out_ready;

   always_comb begin
      count_next = count;
      if (push && !pop)
         count_next = count + 2'd1;
      else if (!push && pop)
         count_next = count - 2'd1;
   end

   // in_ready is registered from the next count, so out_ready never reaches it combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++)
            mem[i] <= '0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         count      <= 2'd0;
         in_ready_q <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= perm;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         count      <= count_next;
         in_ready_q <= (count_next != 2'd2);
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = (count != 2'd0);
   assign bus.out_data  = (count != 2'd0) ? mem[rd_ptr] : '0;

`ifdef LANE_REORDER_PIPE_CNT_EN
   // Clear wins over a same-cycle output handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         beat_cnt <= 32'd0;
      else if (cnt_clr)
         beat_cnt <= 32'd0;
      else if (pop)
         beat_cnt <= beat_cnt + 32'd1;
   end
`endif
endmodule

// File: tb/tb_lane_reorder_pipe.sv
// Bench for lane_reorder_pipe: a LANES=4/W=8 and a LANES=5/W=4 instance, directed vectors,
// scoreboard queues filled on input acceptance and drained by output monitors.
module tb_lane_reorder_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lane_reorder_pipe_if #(.LANE_W(8), .LANES(4)) bus4 ();
  lane_reorder_pipe_if #(.LANE_W(4), .LANES(5)) bus5 ();

`ifdef LANE_REORDER_PIPE_CNT_EN
  logic        cnt_clr4 = 1'b0;
  logic        cnt_clr5 = 1'b0;
  logic [31:0] beat_cnt4;
  logic [31:0] beat_cnt5;
`endif

  lane_reorder_pipe #(.LANE_W(8), .LANES(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
`ifdef LANE_REORDER_PIPE_CNT_EN
    ,
    .cnt_clr  (cnt_clr4),
    .beat_cnt (beat_cnt4)
`endif
  );

  lane_reorder_pipe #(.LANE_W(4), .LANES(5)) u_dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5)
`ifdef LANE_REORDER_PIPE_CNT_EN
    ,
    .cnt_clr  (cnt_clr5),
    .beat_cnt (beat_cnt5)
`endif
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int hs_cnt4  = 0;
  int rdy_mode = 0;  // 0: always ready, 1: stalled, 2: random

  logic [31:0] exp_q4[$];
  logic [31:0] exp_q5[$];

  // Directed vectors with hand-computed results.
  logic [31:0] v4_in[8];
  logic [1:0]  v4_mode[8];
  logic [1:0]  v4_rot[8];
  logic [31:0] v4_exp[8];
  logic [19:0] v5_in[7];
  logic [1:0]  v5_mode[7];
  logic [2:0]  v5_rot[7];
  logic [19:0] v5_exp[7];

  initial begin
    v4_in[0] = 32'h11223344; v4_mode[0] = 2'd0; v4_rot[0] = 2'd0; v4_exp[0] = 32'h11223344;
    v4_in[1] = 32'h11223344; v4_mode[1] = 2'd1; v4_rot[1] = 2'd2; v4_exp[1] = 32'h44332211;
    v4_in[2] = 32'h11223344; v4_mode[2] = 2'd2; v4_rot[2] = 2'd1; v4_exp[2] = 32'h22114433;
    v4_in[3] = 32'h11223344; v4_mode[3] = 2'd3; v4_rot[3] = 2'd1; v4_exp[3] = 32'h22334411;
    v4_in[4] = 32'h11223344; v4_mode[4] = 2'd3; v4_rot[4] = 2'd3; v4_exp[4] = 32'h44112233;
    v4_in[5] = 32'hA1B2C3D4; v4_mode[5] = 2'd1; v4_rot[5] = 2'd3; v4_exp[5] = 32'hD4C3B2A1;
    v4_in[6] = 32'hA1B2C3D4; v4_mode[6] = 2'd2; v4_rot[6] = 2'd0; v4_exp[6] = 32'hB2A1D4C3;
    v4_in[7] = 32'hA1B2C3D4; v4_mode[7] = 2'd3; v4_rot[7] = 2'd2; v4_exp[7] = 32'hC3D4A1B2;
    v5_in[0] = 20'h12345; v5_mode[0] = 2'd0; v5_rot[0] = 3'd0; v5_exp[0] = 20'h12345;
    v5_in[1] = 20'h12345; v5_mode[1] = 2'd1; v5_rot[1] = 3'd0; v5_exp[1] = 20'h54321;
    v5_in[2] = 20'h12345; v5_mode[2] = 2'd2; v5_rot[2] = 3'd0; v5_exp[2] = 20'h13254;
    v5_in[3] = 20'h12345; v5_mode[3] = 2'd3; v5_rot[3] = 3'd1; v5_exp[3] = 20'h23451;
    v5_in[4] = 20'h12345; v5_mode[4] = 2'd3; v5_rot[4] = 3'd6; v5_exp[4] = 20'h23451;
    v5_in[5] = 20'h12345; v5_mode[5] = 2'd3; v5_rot[5] = 3'd7; v5_exp[5] = 20'h34512;
    v5_in[6] = 20'h12345; v5_mode[6] = 2'd3; v5_rot[6] = 3'd4; v5_exp[6] = 20'h51234;
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endfunction

  // out_ready driver, updated just after each rising edge.
  initial begin
    bus4.out_ready = 1'b1;
    bus5.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: begin bus4.out_ready = 1'b1; bus5.out_ready = 1'b1; end
        1: begin bus4.out_ready = 1'b0; bus5.out_ready = 1'b0; end
        default: begin
          bus4.out_ready = 1'($urandom_range(0, 1));
          bus5.out_ready = 1'($urandom_range(0, 1));
        end
      endcase
    end
  end

  // Monitors: sample on the falling edge, compare each output handshake and stall hold.
  logic        stall4 = 1'b0;
  logic [31:0] held4  = '0;
  logic        stall5 = 1'b0;
  logic [19:0] held5  = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall4 = 1'b0;
      end else begin
        if (stall4) begin
          check("hold_valid4", 32'(bus4.out_valid), 32'd1);
          check("hold_data4", bus4.out_data, held4);
        end
        if (bus4.out_valid && bus4.out_ready) begin
          hs_cnt4++;
          if (exp_q4.size() == 0) begin
            chk_cnt++;
            $display("FAIL spurious_beat4: got 0x%08h, expected no beat", bus4.out_data);
          end else begin
            check("out_data4", bus4.out_data, exp_q4.pop_front());
          end
        end
        stall4 = bus4.out_valid && !bus4.out_ready;
        held4  = bus4.out_data;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall5 = 1'b0;
      end else begin
        if (stall5) begin
          check("hold_valid5", 32'(bus5.out_valid), 32'd1);
          check("hold_data5", 32'(bus5.out_data), 32'(held5));
        end
        if (bus5.out_valid && bus5.out_ready) begin
          if (exp_q5.size() == 0) begin
            chk_cnt++;
            $display("FAIL spurious_beat5: got 0x%05h, expected no beat", bus5.out_data);
          end else begin
            check("out_data5", 32'(bus5.out_data), exp_q5.pop_front());
          end
        end
        stall5 = bus5.out_valid && !bus5.out_ready;
        held5  = bus5.out_data;
      end
    end
  end

  // Drivers: called and return just after a rising edge.
  task automatic send4(input logic [31:0] d, input logic [1:0] m, input logic [1:0] r,
                       input logic [31:0] e);
    int   n;
    logic hs;
    n  = 0;
    hs = 1'b0;
    bus4.in_valid = 1'b1;
    bus4.in_data  = d;
    bus4.in_mode  = m;
    bus4.in_rot   = r;
    while (!hs && n < 100) begin
      @(negedge clk);
      hs = bus4.in_ready;
      if (hs) exp_q4.push_back(e);
      @(posedge clk);
      #1;
      n++;
    end
    if (!hs) begin
      chk_cnt++;
      $display("FAIL accept_timeout4: in_ready stayed 0, expected acceptance of 0x%08h", d);
    end
    bus4.in_valid = 1'b0;
    bus4.in_data  = $urandom;
    bus4.in_mode  = 2'($urandom_range(0, 3));
    bus4.in_rot   = 2'($urandom_range(0, 3));
  endtask

  task automatic send5(input logic [19:0] d, input logic [1:0] m, input logic [2:0] r,
                       input logic [19:0] e);
    int   n;
    logic hs;
    n  = 0;
    hs = 1'b0;
    bus5.in_valid = 1'b1;
    bus5.in_data  = d;
    bus5.in_mode  = m;
    bus5.in_rot   = r;
    while (!hs && n < 100) begin
      @(negedge clk);
      hs = bus5.in_ready;
      if (hs) exp_q5.push_back(32'(e));
      @(posedge clk);
      #1;
      n++;
    end
    if (!hs) begin
      chk_cnt++;
      $display("FAIL accept_timeout5: in_ready stayed 0, expected acceptance of 0x%05h", d);
    end
    bus5.in_valid = 1'b0;
    bus5.in_data  = 20'($urandom);
    bus5.in_mode  = 2'($urandom_range(0, 3));
    bus5.in_rot   = 3'($urandom_range(0, 7));
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q4.size() != 0 || exp_q5.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (exp_q4.size() != 0 || exp_q5.size() != 0) begin
      chk_cnt++;
      $display("FAIL drain_timeout: %0d/%0d beats left, expected 0/0", exp_q4.size(), exp_q5.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.in_mode = '0; bus4.in_rot = '0;
    bus5.in_valid = 1'b0; bus5.in_data = '0; bus5.in_mode = '0; bus5.in_rot = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid4", 32'(bus4.out_valid), 32'd0);
    check("rst_out_data4", bus4.out_data, 32'd0);
    check("rst_in_ready4", 32'(bus4.in_ready), 32'd0);
    check("rst_out_valid5", 32'(bus5.out_valid), 32'd0);
`ifdef LANE_REORDER_PIPE_CNT_EN
    check("rst_beat_cnt4", beat_cnt4, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_pre_edge4", 32'(bus4.in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("in_ready_post_edge4", 32'(bus4.in_ready), 32'd1);
    check("in_ready_post_edge5", 32'(bus5.in_ready), 32'd1);

    // First-beat latency: valid right after the accepting edge.
    send4(32'h11223344, 2'd1, 2'd0, 32'h44332211);
    check("latency_valid4", 32'(bus4.out_valid), 32'd1);
    check("latency_data4", bus4.out_data, 32'h44332211);
    for (int i = 0; i < 8; i++) send4(v4_in[i], v4_mode[i], v4_rot[i], v4_exp[i]);
    for (int i = 0; i < 7; i++) send5(v5_in[i], v5_mode[i], v5_rot[i], v5_exp[i]);
    drain();

    // Backpressure: two beats fill the buffer, the third waits.
    rdy_mode = 1;
    @(posedge clk);
    #1;
    send4(32'h01020304, 2'd0, 2'd0, 32'h01020304);
    send4(32'h05060708, 2'd1, 2'd0, 32'h08070605);
    bus4.in_valid = 1'b1;
    bus4.in_data  = 32'h090A0B0C;
    bus4.in_mode  = 2'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_in_ready4", 32'(bus4.in_ready), 32'd0);
      check("full_head4", bus4.out_data, 32'h01020304);
    end
    rdy_mode = 0;
    @(posedge clk);
    #1;
    send4(32'h090A0B0C, 2'd2, 2'd0, 32'h0A090C0B);
    drain();

    // Random ready toggling with idle gaps and garbage on idle inputs.
    rdy_mode = 2;
    for (int rep = 0; rep < 6; rep++) begin
      for (int i = 0; i < 8; i++) begin
        gap();
        send4(v4_in[i], v4_mode[i], v4_rot[i], v4_exp[i]);
      end
      for (int i = 0; i < 7; i++) begin
        gap();
        send5(v5_in[i], v5_mode[i], v5_rot[i], v5_exp[i]);
      end
    end
    drain();
    rdy_mode = 0;
    @(posedge clk);
    #1;

`ifdef LANE_REORDER_PIPE_CNT_EN
    check("beat_cnt_total4", beat_cnt4, 32'(hs_cnt4));
    cnt_clr4 = 1'b1;
    send4(v4_in[0], v4_mode[0], v4_rot[0], v4_exp[0]);
    @(posedge clk);
    #1;
    cnt_clr4 = 1'b0;
    drain();
    check("beat_cnt_clr4", beat_cnt4, 32'd0);
    for (int i = 0; i < 7; i++) send4(v4_in[i], v4_mode[i], v4_rot[i], v4_exp[i]);
    drain();
    check("beat_cnt_seven4", beat_cnt4, 32'd7);
`endif

    // Reset with beats buffered: everything dropped, nothing stale afterwards.
    rdy_mode = 1;
    @(posedge clk);
    #1;
    send4(v4_in[1], v4_mode[1], v4_rot[1], v4_exp[1]);
    send4(v4_in[2], v4_mode[2], v4_rot[2], v4_exp[2]);
    send5(v5_in[1], v5_mode[1], v5_rot[1], v5_exp[1]);
    send5(v5_in[2], v5_mode[2], v5_rot[2], v5_exp[2]);
    check("pre_rst_valid4", 32'(bus4.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid4", 32'(bus4.out_valid), 32'd0);
    check("mid_rst_data4", bus4.out_data, 32'd0);
    check("mid_rst_valid5", 32'(bus5.out_valid), 32'd0);
    check("mid_rst_data5", 32'(bus5.out_data), 32'd0);
    exp_q4.delete();
    exp_q5.delete();
    rdy_mode = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rel_in_ready4", 32'(bus4.in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("rel_in_ready_next4", 32'(bus4.in_ready), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_valid4", 32'(bus4.out_valid), 32'd0);
    check("post_rst_valid5", 32'(bus5.out_valid), 32'd0);
`ifdef LANE_REORDER_PIPE_CNT_EN
    check("post_rst_beat_cnt4", beat_cnt4, 32'd0);
`endif
    send4(v4_in[3], v4_mode[3], v4_rot[3], v4_exp[3]);
    send5(v5_in[5], v5_mode[5], v5_rot[5], v5_exp[5]);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
